// File: rtl/transmitter.sv
// UART transmitter that dumps a 128-bit word as 32 uppercase ASCII hex characters
// (MSB nibble first) followed by CR LF, framed 8N1, LSB first.
module transmitter #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [127:0] data_i,
    output logic         tx_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
    localparam int unsigned CntW       = $clog2(ClksPerBit);

    localparam logic [CntW-1:0] CntLast  = CntW'(ClksPerBit - 1);
    localparam logic [5:0]      LastChar = 6'd33;
    localparam logic [5:0]      CrChar   = 6'd32;
    localparam logic [2:0]      LastBit  = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [5:0]      char_idx_q, char_idx_d;
    logic [127:0]    shadow_q, shadow_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            bit_end;
    logic [7:0]      cur_byte;

    // ASCII code of character idx: hex nibble for 0..31, then CR, then LF.
    function automatic logic [7:0] char_byte(input logic [127:0] sh, input logic [5:0] idx);
        logic [6:0] shamt;
        logic [3:0] nib;
        logic [7:0] res;
        shamt = 7'd124 - {idx[4:0], 2'b00};
        nib   = 4'(sh >> shamt);
        if (idx == CrChar) begin
            res = 8'h0D;
        end else if (idx == LastChar) begin
            res = 8'h0A;
        end else if (nib <= 4'd9) begin
            res = 8'h30 + {4'd0, nib};
        end else begin
            res = 8'h37 + {4'd0, nib};
        end
        return res;
    endfunction

    assign bit_end = (baud_cnt_q == CntLast);

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: baud counter, bit/char indices and the captured word.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            char_idx_q <= '0;
            shadow_q   <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            char_idx_q <= char_idx_d;
            shadow_q   <= shadow_d;
        end
    end

    // Registered outputs so the line never glitches on state decode.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Next-state and datapath update; every bit slot is ClksPerBit cycles.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + CntW'(1);
        bit_idx_d  = bit_idx_q;
        char_idx_d = char_idx_q;
        shadow_d   = shadow_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_cnt_d = '0;
                if (start_i) begin
                    state_d    = StStart;
                    shadow_d   = data_i;
                    char_idx_d = '0;
                    bit_idx_d  = '0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_idx_q == LastBit) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (char_idx_q < LastChar) begin
                        char_idx_d = char_idx_q + 6'd1;
                        state_d    = StStart;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs change on the same edge as the FSM.
    always_comb begin
        cur_byte = char_byte(shadow_d, char_idx_d);
        busy_d   = (state_d != StIdle);
        tx_d     = 1'b1;
        unique case (state_d)
            StIdle:  tx_d = 1'b1;
            StStart: tx_d = 1'b0;
            StData:  tx_d = cur_byte[bit_idx_d];
            StStop:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule
